// File: rtl/cpu_monitor_pkg.sv
// Shared constants for the cpu_monitor byte-stream debug monitor.
//   CMD_*          first byte of a command frame
//   RSP_*          single-byte replies sent back on the tx stream
//   REG_DUMP_BASE  memory address where the CPU leaves its register dump
package cpu_monitor_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_DUMP = 8'h44;
   localparam logic [7:0] CMD_RUN  = 8'h52;

   localparam logic [7:0] RSP_OK   = 8'h4F;
   localparam logic [7:0] RSP_ERR  = 8'h3F;

   localparam int REG_DUMP_BASE = 2;

endpackage

// File: rtl/cpu_monitor_if.sv
// Byte-stream link between the serial front end and the monitor.
//   rx_data/rx_valid/rx_ready  received bytes, front end -> monitor
//   tx_data/tx_valid/tx_ready  bytes to transmit, monitor -> front end
// master = serial front end, slave = monitor.
interface cpu_monitor_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );

endinterface

// File: rtl/cpu_monitor_mem_port_mux.sv
// Memory port selector: sel=1 passes the monitor's port, sel=0 the CPU's.
//   sel                  1 = monitor owns memory
//   mon_*                monitor read/write port
//   cpu_*                CPU read/write port
//   raddr/waddr/data_in/write  port presented to memory
module mem_port_mux #(
   parameter int addr_width = 9
) (
   input  logic                  sel,
   input  logic [addr_width-1:0] mon_raddr,
   input  logic [addr_width-1:0] mon_waddr,
   input  logic [7:0]            mon_data_in,
   input  logic                  mon_write,
   input  logic [addr_width-1:0] cpu_raddr,
   input  logic [addr_width-1:0] cpu_waddr,
   input  logic [7:0]            cpu_data_in,
   input  logic                  cpu_write,
   output logic [addr_width-1:0] raddr,
   output logic [addr_width-1:0] waddr,
   output logic [7:0]            data_in,
   output logic                  write
);

   assign raddr   = sel ? mon_raddr   : cpu_raddr;
   assign waddr   = sel ? mon_waddr   : cpu_waddr;
   assign data_in = sel ? mon_data_in : cpu_data_in;
   assign write   = sel ? mon_write   : cpu_write;

endmodule

// File: rtl/cpu_monitor.sv
// Byte-stream debug monitor: loads/dumps memory while the CPU is held in
// reset, and runs the CPU from a given address until it halts.
//   clk, reset          clock, synchronous active-high reset
//   bus                 rx/tx byte streams (slave side)
//   mem_raddr/mem_waddr memory read/write address
//   mem_data_in         write data, mem_write single-cycle write strobe
//   mem_data_out        synchronous read data
//   mem_sel             1 = monitor owns the memory port
//   cpu_reset           CPU reset (equal to mem_sel)
//   cpu_start_address   CPU start address, cpu_halted CPU halted flag
//
// state  | meaning
// CMD    | wait for command byte
// ADDRH  | receive address high byte
// ADDRL  | receive address low byte
// COUNT  | receive byte count (0 = 256)
// LDATA  | receive load data, one memory write per byte
// DRD    | dump: drive read address
// DW1    | dump: memory read latency
// DLAT   | dump: capture read data
// DTX    | dump: present byte until tx_ready
// RUN    | latch start address, CPU still in reset
// RUN1   | second reset cycle
// RWAIT  | CPU running, wait for cpu_halted
// ACK    | send 'O'
// ERR    | send '?'
module cpu_monitor
   import cpu_monitor_pkg::*;
#(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   cpu_monitor_if.slave          bus,
   output logic [addr_width-1:0] mem_raddr,
   output logic [addr_width-1:0] mem_waddr,
   output logic [7:0]            mem_data_in,
   input  logic [7:0]            mem_data_out,
   output logic                  mem_write,
   output logic                  mem_sel,
   output logic                  cpu_reset,
   output logic [addr_width-1:0] cpu_start_address,
   input  logic                  cpu_halted
);

   typedef enum logic [3:0] {
      S_CMD, S_ADDRH, S_ADDRL, S_COUNT, S_LDATA,
      S_DRD, S_DW1, S_DLAT, S_DTX,
      S_RUN, S_RUN1, S_RWAIT, S_ACK, S_ERR
   } state_t;

   state_t state, state_next;

   logic [7:0]            cmd;
   logic [7:0]            addr_hi;
   logic [addr_width-1:0] addr;
   logic [8:0]            remaining;
   logic [7:0]            rd_data;
   logic [addr_width-1:0] mon_raddr, mon_waddr;
   logic [7:0]            mon_data_in;
   logic                  mon_write;
   logic                  mon_owns;
   logic                  rx_fire;
   logic                  last;

   assign rx_fire = bus.rx_valid && bus.rx_ready;
   assign last    = (remaining == 9'd1);

   always_ff @(posedge clk) begin
      if (reset) state <= S_CMD;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_CMD:
            if (rx_fire)
               state_next = (bus.rx_data == CMD_LOAD || bus.rx_data == CMD_DUMP ||
                             bus.rx_data == CMD_RUN) ? S_ADDRH : S_ERR;
         S_ADDRH: if (rx_fire) state_next = S_ADDRL;
         S_ADDRL: if (rx_fire) state_next = (cmd == CMD_RUN) ? S_RUN : S_COUNT;
         S_COUNT: if (rx_fire) state_next = (cmd == CMD_LOAD) ? S_LDATA : S_DRD;
         S_LDATA: if (rx_fire && last) state_next = S_ACK;
         S_DRD:   state_next = S_DW1;
         S_DW1:   state_next = S_DLAT;
         S_DLAT:  state_next = S_DTX;
         S_DTX:   if (bus.tx_ready) state_next = last ? S_CMD : S_DRD;
         S_RUN:   state_next = S_RUN1;
         S_RUN1:  state_next = S_RWAIT;
         S_RWAIT: if (cpu_halted) state_next = S_ACK;
         S_ACK, S_ERR: if (bus.tx_ready) state_next = S_CMD;
         default: state_next = S_CMD;
      endcase
   end

   // rx_ready is masked while reset is held so the front end sees 0 in reset.
   always_comb begin
      bus.rx_ready = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      mon_owns     = 1'b1;
      case (state)
         S_CMD, S_ADDRH, S_ADDRL, S_COUNT, S_LDATA: bus.rx_ready = !reset;
         S_DTX: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = rd_data;
         end
         S_ACK: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = RSP_OK;
         end
         S_ERR: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = RSP_ERR;
         end
         S_RWAIT: mon_owns = 1'b0;
         default: ;
      endcase
   end

   assign mem_sel   = mon_owns;
   assign cpu_reset = mon_owns;

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd               <= 8'h00;
         addr_hi           <= 8'h00;
         addr              <= '0;
         remaining         <= 9'd0;
         rd_data           <= 8'h00;
         mon_raddr         <= '0;
         mon_waddr         <= '0;
         mon_data_in       <= 8'h00;
         mon_write         <= 1'b0;
         cpu_start_address <= '0;
      end else begin
         mon_write <= 1'b0;
         case (state)
            S_CMD:   if (rx_fire) cmd <= bus.rx_data;
            S_ADDRH: if (rx_fire) addr_hi <= bus.rx_data;
            S_ADDRL: if (rx_fire) addr <= addr_width'({addr_hi, bus.rx_data});
            S_COUNT:
               if (rx_fire)
                  remaining <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
            S_LDATA:
               if (rx_fire) begin
                  mon_waddr   <= addr;
                  mon_data_in <= bus.rx_data;
                  mon_write   <= 1'b1;
                  addr        <= addr + addr_width'(1);
                  remaining   <= remaining - 9'd1;
               end
            S_DRD:  mon_raddr <= addr;
            S_DLAT: rd_data   <= mem_data_out;
            S_DTX:
               if (bus.tx_ready) begin
                  addr      <= addr + addr_width'(1);
                  remaining <= remaining - 9'd1;
               end
            S_RUN:  cpu_start_address <= addr;
            default: ;
         endcase
      end
   end

   // The CPU side is idle here; the real CPU port is muxed outside on mem_sel.
   // Routing through the selector guarantees no monitor write while the CPU owns memory.
   mem_port_mux #(.addr_width(addr_width)) u_mem_port_mux (
      .sel         (mon_owns),
      .mon_raddr   (mon_raddr),
      .mon_waddr   (mon_waddr),
      .mon_data_in (mon_data_in),
      .mon_write   (mon_write),
      .cpu_raddr   ('0),
      .cpu_waddr   ('0),
      .cpu_data_in (8'h00),
      .cpu_write   (1'b0),
      .raddr       (mem_raddr),
      .waddr       (mem_waddr),
      .data_in     (mem_data_in),
      .write       (mem_write)
   );

endmodule

// File: tb/tb_cpu_monitor.sv
// Self-checking bench for cpu_monitor: byte-level command stimulus, a memory
// model behind an external CPU/monitor mux, a fake CPU, and a scoreboard
// comparing tx bytes and memory writes against a reference memory image.
module tb_cpu_monitor;
   import cpu_monitor_pkg::*;

   localparam int AW = 9;

   typedef struct packed {
      logic [8:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cpu_monitor_if bus();

   logic [AW-1:0] mem_raddr, mem_waddr, cpu_start_address;
   logic [7:0]    mem_data_in, mem_data_out;
   logic          mem_write, mem_sel, cpu_reset, cpu_halted;

   cpu_monitor #(.addr_width(AW)) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus),
      .mem_raddr         (mem_raddr),
      .mem_waddr         (mem_waddr),
      .mem_data_in       (mem_data_in),
      .mem_data_out      (mem_data_out),
      .mem_write         (mem_write),
      .mem_sel           (mem_sel),
      .cpu_reset         (cpu_reset),
      .cpu_start_address (cpu_start_address),
      .cpu_halted        (cpu_halted)
   );

   // memory with external mux: monitor port when mem_sel, else fake CPU port
   logic [7:0] mem [512];
   logic       cpu_we;
   logic [8:0] cpu_wa;
   logic [7:0] cpu_wd;
   always @(posedge clk) begin
      if (mem_sel) begin
         if (mem_write) mem[mem_waddr] <= mem_data_in;
      end else if (cpu_we) begin
         mem[cpu_wa] <= cpu_wd;
      end
      mem_data_out <= mem[mem_raddr];
   end

   logic [7:0] ref_mem [512];
   logic [7:0] exp_tx[$];
   wr_t        exp_wr[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       bp_hold = 1'b0;

   function automatic void check(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) begin
      #1;
      bus.tx_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // scoreboard monitor: a transfer happens on the next posedge when both are high now
   wr_t mon_w;
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got 0x%02h, none expected", bus.tx_data);
            end else begin
               check("tx_byte", bus.tx_data, exp_tx.pop_front());
            end
         end
         if (mem_write) begin
            check("wr_owner", mem_sel, 1);
            if (exp_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wr_unexpected: got write 0x%02h@0x%03h, none expected",
                        mem_data_in, mem_waddr);
            end else begin
               mon_w = exp_wr.pop_front();
               check("wr_addr", mem_waddr, mon_w.a);
               check("wr_data", mem_data_in, mon_w.d);
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if ($urandom_range(0, 3) == 0) sync();
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready && n < 3000) begin
         n++;
         @(negedge clk);
      end
      if (!bus.rx_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_timeout: byte 0x%02h not accepted, rx_ready=%0b required 1", b, bus.rx_ready);
      end
      sync();
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_load(input logic [8:0] a, input logic [7:0] data[$]);
      logic [8:0] ai;
      for (int i = 0; i < data.size(); i++) begin
         ai = a + 9'(i);
         exp_wr.push_back('{ai, data[i]});
         ref_mem[ai] = data[i];
      end
      exp_tx.push_back(RSP_OK);
      send_byte(CMD_LOAD);
      send_byte({7'($urandom), a[8]});
      send_byte(a[7:0]);
      send_byte(8'(data.size()));
      for (int i = 0; i < data.size(); i++) send_byte(data[i]);
   endtask

   task automatic do_dump(input logic [8:0] a, input int n);
      for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[a + 9'(i)]);
      send_byte(CMD_DUMP);
      send_byte({7'($urandom), a[8]});
      send_byte(a[7:0]);
      send_byte(8'(n));
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_pending", exp_tx.size() + exp_wr.size(), 0);
      exp_tx.delete();
      exp_wr.delete();
      sync();
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "global timeout");
   end

   initial begin
      logic [8:0] a;
      logic [7:0] d[$];
      logic [7:0] b;
      logic [7:0] tx_hold;
      logic [8:0] raddr_hold;
      int         n;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      cpu_halted   = 1'b0;
      cpu_we       = 1'b0;
      cpu_wa       = 9'h000;
      cpu_wd       = 8'h00;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rx_ready", bus.rx_ready, 0);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_raddr", mem_raddr, 0);
      check("rst_mem_waddr", mem_waddr, 0);
      check("rst_mem_data_in", mem_data_in, 0);
      check("rst_cpu_start", cpu_start_address, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_mem_sel", mem_sel, 1);
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("cmd_rx_ready", bus.rx_ready, 1);
      sync();

      // load then dump
      d = '{8'hAA, 8'hBB, 8'hCC};
      do_load(9'h010, d);
      wait_drain();
      do_dump(9'h010, 3);
      wait_drain();

      // address wrap
      d = '{8'h11, 8'h22};
      do_load(9'h1FF, d);
      wait_drain();
      do_dump(9'h1FF, 2);
      wait_drain();

      // randomized load/dump pairs
      for (int k = 0; k < 6; k++) begin
         a = 9'($urandom);
         d = {};
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) d.push_back(8'($urandom));
         do_load(a, d);
         wait_drain();
         do_dump(a, n);
         wait_drain();
      end

      // bad command bytes, each answered with '?'
      for (int k = 0; k < 3; k++) begin
         b = (k == 0) ? 8'h5A : 8'($urandom);
         while (b == CMD_LOAD || b == CMD_DUMP || b == CMD_RUN) b = 8'($urandom);
         exp_tx.push_back(RSP_ERR);
         send_byte(b);
         wait_drain();
         @(negedge clk);
         check("err_back_to_cmd", bus.rx_ready, 1);
         sync();
      end
      do_dump(9'h000, 1);
      wait_drain();

      // backpressure during a dump
      a = 9'($urandom);
      d = {};
      for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
      do_load(a, d);
      wait_drain();
      bp_hold = 1'b1;
      do_dump(a, 4);
      n = 0;
      @(negedge clk);
      while (!bus.tx_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("bp_tx_valid_seen", bus.tx_valid, 1);
      tx_hold    = bus.tx_data;
      raddr_hold = mem_raddr;
      check("bp_first_byte", tx_hold, d[0]);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_tx_valid", bus.tx_valid, 1);
         check("bp_tx_data", bus.tx_data, tx_hold);
         check("bp_raddr", mem_raddr, raddr_hold);
      end
      bp_hold = 1'b0;
      sync();
      wait_drain();

      // count 0 = 256 bytes
      a = 9'($urandom);
      d = {};
      for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
      do_load(a, d);
      wait_drain();
      do_dump(a, 256);
      wait_drain();

      // run: program at 0x004 ending FF FF
      d = {};
      for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
      d.push_back(8'hFF);
      d.push_back(8'hFF);
      do_load(9'h004, d);
      wait_drain();
      exp_tx.push_back(RSP_OK);
      send_byte(CMD_RUN);
      send_byte({7'($urandom), 1'b0});
      send_byte(8'h04);
      @(negedge clk);
      check("run_rst_c0", cpu_reset, 1);
      check("run_sel_c0", mem_sel, 1);
      @(negedge clk);
      check("run_rst_c1", cpu_reset, 1);
      @(negedge clk);
      check("run_rst_low", cpu_reset, 0);
      check("run_sel_low", mem_sel, 0);
      check("run_start_addr", cpu_start_address, 9'h004);
      sync();
      // fake CPU writes its register dump, r0 = 00 00 00 00
      for (int i = 0; i < 64; i++) begin
         cpu_wa = 9'(REG_DUMP_BASE + i);
         cpu_wd = (i < 4) ? 8'h00 : 8'(i * 29 + 3);
         cpu_we = 1'b1;
         ref_mem[cpu_wa] = cpu_wd;
         sync();
      end
      cpu_we = 1'b0;
      check("run_still_running", cpu_reset, 0);
      cpu_halted = 1'b1;
      @(posedge clk);
      #1;
      cpu_halted = 1'b0;
      @(negedge clk);
      check("halt_cpu_reset", cpu_reset, 1);
      check("halt_mem_sel", mem_sel, 1);
      sync();
      wait_drain();
      do_dump(9'(REG_DUMP_BASE), 64);
      wait_drain();

      // reset while the CPU runs
      send_byte(CMD_RUN);
      send_byte(8'h00);
      send_byte(8'h20);
      n = 0;
      @(negedge clk);
      while (cpu_reset && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("rwait_reached", cpu_reset, 0);
      sync();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_cpu_reset", cpu_reset, 1);
      check("midrst_mem_sel", mem_sel, 1);
      check("midrst_tx_valid", bus.tx_valid, 0);
      check("midrst_mem_write", mem_write, 0);
      check("midrst_start", cpu_start_address, 0);
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("midrst_cmd_ready", bus.rx_ready, 1);
      sync();
      repeat (5) sync();
      check("midrst_no_ack", bus.tx_valid, 0);
      do_dump(9'h010, 3);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_monitor.md
Name: cpu_monitor

Overview:
- Byte-stream debug monitor that sits between a serial front end (UART rx/tx byte interfaces) and the CPU/memory pair.
- While the CPU is held in reset, the monitor owns the memory port and can load bytes into memory and dump them back out.
- On a run command it sets the CPU start address, releases CPU reset and waits for the CPU's halted flag. The CPU's register dump is then readable from address 2 onward.

Parameters:
addr_width, 9, memory address width; must match the CPU and memory.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  monitor accepts rx byte this cycle
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte
mem_raddr  output  addr_width  memory read address (registered)
mem_waddr  output  addr_width  memory write address (registered)
mem_data_in  output  8  write data to memory
mem_data_out  input  8  read data from memory
mem_write  output  1  single-cycle write strobe
mem_sel  output  1  1 = monitor drives the memory port, 0 = CPU drives it (external mux)
cpu_reset  output  1  reset to the CPU, active-high
cpu_start_address  output  addr_width  start address to the CPU
cpu_halted  input  1  CPU halted flag

Behaviour:
- Reset values:
  - 0: rx_ready, tx_valid, tx_data, mem_write, all addresses, mem_data_in, cpu_start_address.
  - 1: cpu_reset, mem_sel.
  - State = CMD.
- Handshakes:
  - A byte transfers on any edge where valid and ready are both high.
  - tx_data is held stable while tx_valid=1 until tx_ready.
  - rx_ready=1 only in the byte-receive states (CMD, ADDRH, ADDRL, COUNT, LDATA). It is 0 in all other states.
- Commands, first byte:
  - 'L' (0x4C): load. Operands: addr hi, addr lo, count, then count data bytes.
  - 'D' (0x44): dump. Operands: addr hi, addr lo, count.
  - 'R' (0x52): run. Operands: addr hi, addr lo.
  - Any other byte: reply '?' (0x3F) and return to CMD.
- Address = {hi,lo}[addr_width-1:0]. The address increments modulo 2^addr_width (wraps 0x1FF -> 0x000).
- count is 8 bits; count 0 means 256 bytes.
- States:
  - CMD -> ADDRH -> ADDRL; 'R' branches from ADDRL to RUN.
  - 'L'/'D': ADDRL -> COUNT, then per command as below.
- L: COUNT -> LDATA.
  - Each accepted byte sets mem_waddr=addr and mem_data_in=byte, and pulses mem_write for exactly 1 cycle on the following cycle.
  - Address increments, remaining count decrements.
  - After the last write, go to ACK.
- D: COUNT -> DRD.
  - DRD sets mem_raddr=addr.
  - DW1 is a wait cycle.
  - DLAT samples mem_data_out into tx_data and asserts tx_valid. Read data is sampled 2 cycles after mem_raddr is assigned.
  - DTX holds until tx_ready, then increments the address.
  - Repeat until count is exhausted, then return to CMD (no ack byte).
- R:
  - RUN: cpu_start_address<=addr; cpu_reset is held at 1 for 2 cycles (RUN, RUN1).
  - Then cpu_reset<=0 and mem_sel<=0; enter RWAIT.
  - RWAIT waits on cpu_halted=1 for an unbounded time.
  - Then cpu_reset<=1 and mem_sel<=1, go to ACK.
- ACK: tx_data='O' (0x4F), tx_valid=1 until tx_ready, then go to CMD.
- mem_sel and cpu_reset are equal in all states.
- The monitor never drives mem_write while mem_sel=0.
- Reset in any state (including RWAIT) returns all outputs to their reset values. The CPU is forced back into reset and any command in progress is dropped.
- cpu_halted is ignored outside RWAIT.
- rx bytes arriving while rx_ready=0 are the front end's responsibility; the monitor does not buffer them.

Decomposition:
- Shared package holds:
  - command byte constants: CMD_LOAD 0x4C, CMD_DUMP 0x44, CMD_RUN 0x52;
  - reply constants: RSP_OK 0x4F, RSP_ERR 0x3F;
  - the register-dump base address constant 2.
- The state encoding is local to the block.
- One sub-module is natural: mem_port_mux, which selects CPU vs monitor raddr/waddr/data_in/write on mem_sel.

Test Plan:
- Load then dump: rx 4C 00 10 03 AA BB CC, then 44 00 10 03.
  - Writes AA@0x010, BB@0x011, CC@0x012, one mem_write pulse each.
  - tx 4F, then tx AA BB CC.
- Wrap: load 4C 01 FF 02 11 22.
  - 11@0x1FF, 22@0x000.
  - Dump 44 01 FF 02 returns 11 22.
- Run: load a program at 0x004 ending in FF FF, then rx 52 00 04.
  - cpu_start_address=0x004; cpu_reset high for 2 cycles then low; mem_sel=0.
  - After cpu_halted, cpu_reset=1 and mem_sel=1, tx 4F.
  - Dump 44 00 02 40 returns the 64-byte register dump, starting 00 00 00 00 for r0.
- Bad command: rx 5A -> tx 3F and state CMD; next 44 00 00 01 works normally.
- Backpressure: during a dump, hold tx_ready=0 for 10 cycles -> tx_data and tx_valid stay stable and the address does not advance.
- Count 0: load with count 00 accepts 256 data bytes, then tx 4F.
- Reset mid-operation: reset during RWAIT -> cpu_reset=1 and mem_sel=1 next cycle, tx_valid=0, state CMD.
